muldiv_ctrl: RTL

Multi-cycle multiply/divide sequencer for the E stage of the pipelined MIPS CPU. It accepts a start request with operation code and operands from the E-stage datapath, and runs a fixed-latency countdown per operation class. It drives the busy signal the hazard unit uses to stall HI/LO-dependent instructions, and owns the architectural HI/LO registers, including commit, mthi/mtlo writes, and interrupt/exception cancellation.

---
 rtl/muldiv_ctrl_pkg.sv | 46 ++++
 rtl/muldiv_ctrl_if.sv | 28 ++
 rtl/muldiv_ctrl_arith.sv | 68 ++++++
 rtl/muldiv_ctrl.sv | 99 +++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared definitions for the E-stage multiply/divide sequencer.
// Holds the mul/div op encodings (also used by the control-unit decode),
// the sequencer FSM state constants, the {hi,lo} result payload and small
// op-classification helpers.
package muldiv_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned CNT_W  = 4;

  // Op encodings on the op bus; values 7..15 behave as MD_NONE.
  typedef enum logic [OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } md_result_t;

  // Ops that launch a multi-cycle busy window.
  function automatic logic op_is_arith(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Any op that has an architectural effect when launched.
  function automatic logic op_is_valid(input logic [OP_W-1:0] op);
    return op_is_arith(op) || (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: E-stage datapath <-> mul/div sequencer bundle.
//   master (E-stage): drives start, op, cancel, rs_data, rt_data;
//                     observes busy, done, hi, lo.
//   slave  (sequencer): the reverse.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic              start;
  logic [OP_W-1:0]   op;
  logic              cancel;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, cancel, rs_data, rt_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, cancel, rs_data, rt_data,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_ctrl_arith.sv
// muldiv_ctrl_arith: combinational mul/div datapath.
//   op          in   operation code (mult/multu/div/divu; others give zero)
//   rs_data     in   multiplicand / dividend
//   rt_data     in   multiplier / divisor
//   result      out  {hi,lo}: product, or {remainder, quotient}
//   div_by_zero out  divide op with a zero divisor (result must not commit)
module muldiv_ctrl_arith
  import muldiv_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output md_result_t        result,
  output logic              div_by_zero
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] prod_s;
  logic [PROD_W-1:0] prod_u;
  logic [DATA_W-1:0] divisor;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W-1:0] q_mag;
  logic [DATA_W-1:0] r_mag;
  logic [DATA_W-1:0] q_s;
  logic [DATA_W-1:0] r_s;
  logic [DATA_W-1:0] q_u;
  logic [DATA_W-1:0] r_u;
  logic              a_neg;
  logic              b_neg;
  logic              rt_zero;

  // Signed math by sign-extension / magnitude so only unsigned operators are used.
  always_comb begin
    prod_s  = {{DATA_W{rs_data[DATA_W-1]}}, rs_data} * {{DATA_W{rt_data[DATA_W-1]}}, rt_data};
    prod_u  = {{DATA_W{1'b0}}, rs_data} * {{DATA_W{1'b0}}, rt_data};

    rt_zero = (rt_data == '0);
    // Substitute 1 for a zero divisor so the dividers never see /0; the result is dropped.
    divisor = rt_zero ? DATA_W'(1) : rt_data;

    a_neg   = rs_data[DATA_W-1];
    b_neg   = divisor[DATA_W-1];
    a_mag   = a_neg ? (DATA_W'(0) - rs_data) : rs_data;
    b_mag   = b_neg ? (DATA_W'(0) - divisor) : divisor;
    q_mag   = a_mag / b_mag;
    r_mag   = a_mag % b_mag;
    // Truncate toward zero; remainder follows the dividend. 0x80000000/-1 wraps to 0x80000000.
    q_s     = (a_neg ^ b_neg) ? (DATA_W'(0) - q_mag) : q_mag;
    r_s     = a_neg ? (DATA_W'(0) - r_mag) : r_mag;

    q_u     = rs_data / divisor;
    r_u     = rs_data % divisor;

    result  = '0;
    case (op)
      MD_MULT:  result = md_result_t'(prod_s);
      MD_MULTU: result = md_result_t'(prod_u);
      MD_DIV:   result = '{hi: r_s, lo: q_s};
      MD_DIVU:  result = '{hi: r_u, lo: q_u};
      default:  result = '0;
    endcase

    div_by_zero = rt_zero & op_is_div(op);
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: E-stage multiply/divide sequencer and HI/LO register owner.
//   clk, reset  clock, synchronous active-high reset
//   md (slave)  start/op/cancel/rs_data/rt_data in; busy/done/hi/lo out
// mult/multu run MULT_CYCLES busy cycles, div/divu DIV_CYCLES; the result is
// computed at launch, held in pend_q and committed to hi/lo on the last busy
// cycle with a one-cycle done pulse. mthi/mtlo write in a single cycle.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_ctrl_if.slave  md
);

  md_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  md_result_t        pend_q;
  logic              pend_dz_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  md_result_t        arith_res;
  logic              arith_dz;
  logic              go_c;

  muldiv_ctrl_arith u_arith (
    .op          (md.op),
    .rs_data     (md.rs_data),
    .rt_data     (md.rt_data),
    .result      (arith_res),
    .div_by_zero (arith_dz)
  );

  // A flushed instruction, a busy unit or a no-op never launches.
  assign go_c = md.start & ~md.cancel & ~busy_q & op_is_valid(md.op);

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_dz_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (go_c) begin
            if (op_is_arith(md.op)) begin
              pend_q    <= arith_res;
              pend_dz_q <= arith_dz;
              cnt_q     <= op_is_div(md.op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              busy_q    <= 1'b1;
              state_q   <= MD_RUN;
            end else if (md.op == MD_MTHI) begin
              hi_q <= md.rs_data;
            end else begin
              lo_q <= md.rs_data;
            end
          end
        end
        MD_RUN: begin
          // In-flight ops are older than anything being cancelled, so cancel is ignored here.
          if (cnt_q == CNT_W'(1)) begin
            if (!pend_dz_q) begin
              hi_q <= pend_q.hi;
              lo_q <= pend_q.lo;
            end
            cnt_q   <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= MD_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
